// File: rtl/pipeline_operand_unit_if.sv
// pipeline_operand_unit_if: decode-side operand request, EX/MEM result feed and writeback bus.
interface pipeline_operand_unit_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_ra_addr;
    logic [REG_ADDR_WIDTH-1:0] id_rb_addr;
    logic                      id_ra_used;
    logic                      id_rb_used;
    logic                      id_wr_en;
    logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
    logic                      id_is_load;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     ex_result;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic                      stall;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;

    modport master (
        output id_valid, id_ra_addr, id_rb_addr, id_ra_used, id_rb_used,
               id_wr_en, id_rd_addr, id_is_load, flush, ex_result, mem_rdata,
        input  op_a, op_b, stall, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  id_valid, id_ra_addr, id_rb_addr, id_ra_used, id_rb_used,
               id_wr_en, id_rd_addr, id_is_load, flush, ex_result, mem_rdata,
        output op_a, op_b, stall, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/pipeline_operand_unit.sv
// pipeline_operand_unit: register file, in-flight result chain, youngest-wins forwarding and load-use stall.
module pipeline_operand_unit #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int FWD_DEPTH      = 3
) (
    input logic                    clk,
    input logic                    rst,
    pipeline_operand_unit_if.slave bus
);
    logic [FWD_DEPTH:1]        v_q, v_d, we_q, we_d, ld_q, ld_d, rdy;
    logic [REG_ADDR_WIDTH-1:0] rd_q   [1:FWD_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] rd_d   [1:FWD_DEPTH];
    logic [DATA_WIDTH-1:0]     data_q [2:FWD_DEPTH];
    logic [DATA_WIDTH-1:0]     data_d [2:FWD_DEPTH];
    logic [DATA_WIDTH-1:0]     eff    [1:FWD_DEPTH];
    logic [DATA_WIDTH-1:0]     rf_q   [NUM_REGS];
    logic [REG_ADDR_WIDTH-1:0] src_addr [2];
    logic [1:0]                src_used, hazard;
    logic [DATA_WIDTH-1:0]     op [2];

    // S1 data is the live ALU result; a load only becomes ready in S2 via mem_rdata
    for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_eff
        if (k == 1) begin : g_s1
            assign eff[k] = bus.ex_result;
            assign rdy[k] = ~ld_q[k];
        end else if (k == 2) begin : g_s2
            assign eff[k] = ld_q[k] ? bus.mem_rdata : data_q[k];
            assign rdy[k] = 1'b1;
        end else begin : g_sn
            assign eff[k] = data_q[k];
            assign rdy[k] = 1'b1;
        end
    end

    assign src_addr[0] = bus.id_ra_addr;
    assign src_addr[1] = bus.id_rb_addr;
    assign src_used    = {bus.id_rb_used, bus.id_ra_used};

    // Oldest-to-youngest scan so the lowest matching stage overrides
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            op[s]     = (int'(src_addr[s]) < NUM_REGS) ? rf_q[src_addr[s]] : '0;
            hazard[s] = 1'b0;
            if (src_used[s] && src_addr[s] != '0)
                for (int k = FWD_DEPTH; k >= 1; k--)
                    if (v_q[k] && we_q[k] && rd_q[k] == src_addr[s]) begin
                        op[s]     = eff[k];
                        hazard[s] = ~rdy[k];
                    end
        end
    end

    assign bus.op_a    = op[0];
    assign bus.op_b    = op[1];
    assign bus.stall   = bus.id_valid & ~bus.flush & (|hazard);
    assign bus.wb_en   = v_q[FWD_DEPTH] & we_q[FWD_DEPTH] & (rd_q[FWD_DEPTH] != '0);
    assign bus.wb_addr = rd_q[FWD_DEPTH];
    assign bus.wb_data = eff[FWD_DEPTH];

    always_comb begin
        v_d[1]  = bus.id_valid & ~bus.stall & ~bus.flush;
        we_d[1] = bus.id_wr_en;
        ld_d[1] = bus.id_is_load;
        rd_d[1] = bus.id_rd_addr;
        for (int k = 2; k <= FWD_DEPTH; k++) begin
            v_d[k]    = v_q[k-1];
            we_d[k]   = we_q[k-1];
            ld_d[k]   = ld_q[k-1];
            rd_d[k]   = rd_q[k-1];
            data_d[k] = eff[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q  <= '0;
            we_q <= '0;
            ld_q <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) rd_q[k] <= '0;
            for (int k = 2; k <= FWD_DEPTH; k++) data_q[k] <= '0;
        end else begin
            v_q    <= v_d;
            we_q   <= we_d;
            ld_q   <= ld_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    // wb_en already excludes r0, so rf_q[0] stays zero forever
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
        end else if (bus.wb_en && int'(bus.wb_addr) < NUM_REGS) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_pipeline_operand_unit.sv
// tb_pipeline_operand_unit: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_pipeline_operand_unit;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam logic [5:0] MA = 6'd1, MB = 6'd2, MS = 6'd4, ME = 6'd8, MWA = 6'd16, MWD = 6'd32;
    localparam logic [5:0] ALL = 6'h3f;

    typedef struct {
        string          name;
        logic [5:0]     m;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic           s;
        logic           we;
        logic [AW-1:0]  wa;
        logic [DW-1:0]  wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_operand_unit_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    pipeline_operand_unit #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_REGS(32), .FWD_DEPTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic drive(input logic v, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic ua, input logic ub, input logic we, input logic [AW-1:0] rd,
                         input logic ld, input logic fl, input logic [DW-1:0] ex, input logic [DW-1:0] mem);
        bus.id_valid   = v;
        bus.id_ra_addr = ra;
        bus.id_rb_addr = rb;
        bus.id_ra_used = ua;
        bus.id_rb_used = ub;
        bus.id_wr_en   = we;
        bus.id_rd_addr = rd;
        bus.id_is_load = ld;
        bus.flush      = fl;
        bus.ex_result  = ex;
        bus.mem_rdata  = mem;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_o(input string name, input logic [5:0] m, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic s, input logic we,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        sb.push_back('{name, m, a, b, s, we, wa, wd});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.m[0]) cmp({e.name, " op_a"}, bus.op_a, e.a);
            if (e.m[1]) cmp({e.name, " op_b"}, bus.op_b, e.b);
            if (e.m[2]) cmp({e.name, " stall"}, DW'(bus.stall), DW'(e.s));
            if (e.m[3]) cmp({e.name, " wb_en"}, DW'(bus.wb_en), DW'(e.we));
            if (e.m[4]) cmp({e.name, " wb_addr"}, DW'(bus.wb_addr), DW'(e.wa));
            if (e.m[5]) cmp({e.name, " wb_data"}, bus.wb_data, e.wd);
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        tick();
        drive(1, 5, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_o("reset_read", ALL, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        expect_o("post_reset_read", MA|MB|MS|ME, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        tick();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 'h11, 0);
        expect_o("s1_fwd", MA|MS, 'h11, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_o("s3_fwd_wb", MB|ME|MWA|MWD, 0, 'h11, 0, 1, 3, 'h11);
        tick();
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        expect_o("ld_issue", MS|ME, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 4, 0, 1, 1, 6, 0, 0, 0, 0);
        expect_o("ld_use_stall", MS, 0, 0, 1, 0, 0, 0);
        tick();
        drive(1, 0, 4, 0, 1, 1, 6, 0, 0, 0, 'hDEAD);
        expect_o("ld_use_fwd", MB|MS, 0, 'hDEAD, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h66, 0);
        expect_o("ld_wb", ME|MWA|MWD, 0, 0, 0, 1, 4, 'hDEAD);
        tick();
        drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_o("bubble_wb_rf_read", MA|ME, 'hDEAD, 0, 0, 0, 0, 0);
        tick();
        idle();
        expect_o("r6_wb", ME|MWA|MWD, 0, 0, 0, 1, 6, 'h66);
        tick();
        drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h5, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        tick();
        drive(1, 2, 2, 1, 1, 0, 0, 0, 0, 'h9, 0);
        expect_o("youngest_wins", ALL, 'h9, 'h9, 0, 1, 2, 'h5);
        tick();
        idle();
        tick();
        expect_o("r2_wb", ME|MWA|MWD, 0, 0, 0, 1, 2, 'h9);
        tick();
        drive(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_o("rf_read_r2", MA, 'h9, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 'hFF, 0);
        expect_o("r0_read", MA|MS, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_o("r0_no_wb", MA|ME, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0, 1, 8, 1, 0, 0, 0);
        expect_o("r0_after_wb", MA|MS, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 0, 1, 0, 1, 9, 0, 1, 0, 0);
        expect_o("flush_no_stall", MS, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 'hBEEF);
        expect_o("ld_fwd_after_flush", MA|MS, 'hBEEF, 0, 0, 0, 0, 0);
        tick();
        idle();
        expect_o("r8_wb", ME|MWA|MWD, 0, 0, 0, 1, 8, 'hBEEF);
        tick();
        expect_o("flush_bubble", ME, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 11, 0, 0, 'hA, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 12, 0, 0, 'hB, 0);
        tick();
        rst = 1'b0;
        drive(0, 3, 4, 1, 1, 0, 0, 0, 0, 'hC, 0);
        expect_o("mid_reset", ALL, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_o("rst_rf_clear", MA|MB|MS|ME, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 10, 11, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_o("rst_no_wb1", MA|MB|MS|ME, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 12, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_o("rst_no_wb2", MA|MB|MS|ME, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
